// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost flags, flush and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output; default is registered read.
module sync_fifo_flagged #(
  parameter int DATA_WIDTH          = 32,
  parameter int DATA_DEPTH          = 8,
  parameter int ALMOST_FULL_THRESH  = DATA_DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            clear,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic                            write_en,
  input  logic                            read_en,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic                            empty,
  output logic                            full,
  output logic                            almost_empty,
  output logic                            almost_full,
  output logic [$clog2(DATA_DEPTH+1)-1:0] count,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int CW = $clog2(DATA_DEPTH + 1);
  localparam int PW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DATA_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_THRESH);
  localparam logic [PW-1:0] LAST_C  = PW'(DATA_DEPTH - 1);

  if (DATA_WIDTH < 1) begin : g_chk_width
    $fatal(1, "sync_fifo_flagged: DATA_WIDTH must be >= 1");
  end
  if (DATA_DEPTH < 2) begin : g_chk_depth
    $fatal(1, "sync_fifo_flagged: DATA_DEPTH must be >= 2");
  end
  if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DATA_DEPTH) begin : g_chk_af
    $fatal(1, "sync_fifo_flagged: ALMOST_FULL_THRESH out of 1..DATA_DEPTH");
  end
  if (ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH >= DATA_DEPTH) begin : g_chk_ae
    $fatal(1, "sync_fifo_flagged: ALMOST_EMPTY_THRESH out of 0..DATA_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  flush, rd_ok, wr_ok;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    flush    = reset || clear;
    rd_ok    = read_en && (count_q != '0);
    wr_ok    = write_en && ((count_q != DEPTH_C) || rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = write_en && !wr_ok;
    udf_d    = read_en && !rd_ok;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!flush && wr_ok) mem_q[wr_ptr_q] <= din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (flush)      dout_d = '0;
    else if (rd_ok) dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign dout = dout_q;
`endif

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Randomized scoreboard bench for sync_fifo_flagged.
// Two instances (depth 8 and depth 5) share stimulus; each has its own queue model.
module tb_sync_fifo_flagged;

  localparam int DW = 8;

  typedef struct {
    int          cnt;
    logic [DW-1:0] dout;
    bit          em, fu, ae, af, ov, un;
  } exp_t;

  logic          clock;
  logic          reset, clear, write_en, read_en;
  logic [DW-1:0] din;

  int vectors;
  int miscompares;
  bit done;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D  = (g == 0) ? 8 : 5;
    localparam int AF = (g == 0) ? 6 : 4;
    localparam int AE = (g == 0) ? 2 : 1;
    localparam int CW = $clog2(D + 1);

    logic [DW-1:0] dout;
    logic          empty, full, almost_empty, almost_full;
    logic          overflow, underflow;
    logic [CW-1:0] count;

    sync_fifo_flagged #(
      .DATA_WIDTH(DW),
      .DATA_DEPTH(D),
      .ALMOST_FULL_THRESH(AF),
      .ALMOST_EMPTY_THRESH(AE)
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .clear(clear),
      .din(din),
      .write_en(write_en),
      .read_en(read_en),
      .dout(dout),
      .empty(empty),
      .full(full),
      .almost_empty(almost_empty),
      .almost_full(almost_full),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
    );

    logic [DW-1:0] mq[$];
    exp_t          eq[$];
    logic [DW-1:0] last_rd = '0;

    always @(posedge clock) begin : model
      bit   rd, wr, ov, un;
      exp_t e;
      if (reset || clear) begin
        mq.delete();
        last_rd = '0;
        ov = 1'b0;
        un = 1'b0;
      end else begin
        rd = read_en && (mq.size() != 0);
        wr = write_en && ((mq.size() != D) || rd);
        ov = write_en && !wr;
        un = read_en && !rd;
        if (rd) last_rd = mq.pop_front();
        if (wr) mq.push_back(din);
      end
      e.cnt = mq.size();
`ifdef SYNC_FIFO_FWFT_EN
      e.dout = (mq.size() != 0) ? mq[0] : '0;
`else
      e.dout = last_rd;
`endif
      e.em = (e.cnt == 0);
      e.fu = (e.cnt == D);
      e.ae = (e.cnt <= AE);
      e.af = (e.cnt >= AF);
      e.ov = ov;
      e.un = un;
      eq.push_back(e);
    end

    always @(negedge clock) begin : monitor
      exp_t e;
      if (eq.size() != 0) begin
        e = eq.pop_front();
        vectors++;
        if (count !== CW'(e.cnt) || dout !== e.dout ||
            empty !== e.em || full !== e.fu ||
            almost_empty !== e.ae || almost_full !== e.af ||
            overflow !== e.ov || underflow !== e.un) begin
          miscompares++;
          $display("FAIL depth%0d t=%0t got cnt=%0d dout=%h e/f/ae/af/ov/un=%b%b%b%b%b%b want cnt=%0d dout=%h e/f/ae/af/ov/un=%b%b%b%b%b%b",
                   D, $time, count, dout, empty, full, almost_empty,
                   almost_full, overflow, underflow, e.cnt, e.dout,
                   e.em, e.fu, e.ae, e.af, e.ov, e.un);
        end
      end
    end
  end

  task automatic drive(input bit rst, input bit clr, input bit we,
                       input bit re, input logic [DW-1:0] d);
    reset    = rst;
    clear    = clr;
    write_en = we;
    read_en  = re;
    din      = d;
    @(negedge clock);
  endtask

  task automatic chk_rst(input int id, input int cnt, input logic [DW-1:0] d,
                         input bit em, input bit fu, input bit ae,
                         input bit af, input bit ov, input bit un);
    if (cnt != 0 || d !== '0 || em !== 1'b1 || fu !== 1'b0 ||
        ae !== 1'b1 || af !== 1'b0 || ov !== 1'b0 || un !== 1'b0) begin
      miscompares++;
      $display("FAIL reset state inst%0d cnt=%0d dout=%h e/f/ae/af/ov/un=%b%b%b%b%b%b",
               id, cnt, d, em, fu, ae, af, ov, un);
    end
  endtask

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: test did not finish in time");
      $finish;
    end
  end

  int wp;

  initial begin
    done        = 1'b0;
    vectors     = 0;
    miscompares = 0;
    drive(1, 0, 0, 0, '0);
    drive(1, 0, 1, 1, 8'h55);
    chk_rst(0, int'(g_dut[0].count), g_dut[0].dout, g_dut[0].empty,
            g_dut[0].full, g_dut[0].almost_empty, g_dut[0].almost_full,
            g_dut[0].overflow, g_dut[0].underflow);
    chk_rst(1, int'(g_dut[1].count), g_dut[1].dout, g_dut[1].empty,
            g_dut[1].full, g_dut[1].almost_empty, g_dut[1].almost_full,
            g_dut[1].overflow, g_dut[1].underflow);
    drive(0, 0, 0, 0, '0);

    for (int i = 1; i <= 9; i++) drive(0, 0, 1, 0, DW'(i));
    drive(0, 0, 0, 0, '0);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, '0);
    drive(0, 0, 0, 0, '0);

    for (int i = 1; i <= 8; i++) drive(0, 0, 1, 0, DW'(8'h10 + i));
    drive(0, 0, 1, 1, 8'hA5);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, '0);

    drive(0, 0, 1, 1, 8'h3C);
    drive(0, 0, 0, 1, '0);
    drive(0, 0, 0, 0, '0);

    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, DW'($urandom));
    drive(0, 1, 1, 0, 8'hEE);
    drive(0, 0, 0, 1, '0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, DW'($urandom));
    drive(1, 0, 1, 1, 8'hDD);
    drive(0, 0, 1, 0, 8'h77);
    drive(0, 0, 0, 1, '0);
    drive(0, 0, 0, 1, '0);

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 150; i++) begin
        wp = (p == 0) ? 75 : ((p == 1) ? 25 : 50);
        drive($urandom_range(0, 149) == 0,
              $urandom_range(0, 79) == 0,
              $urandom_range(0, 99) < wp,
              $urandom_range(0, 99) < (100 - wp),
              DW'($urandom));
      end
    end

    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 0, DW'($urandom));
      drive(0, 0, 0, 1, '0);
    end

    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);
    #1;
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) $display("FAIL");
    else                  $display("PASS");
    $finish;
  end

endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
Parametrised successor to the single-clock FIFO: same push/pop core, generalised to any depth ≥ 2, including non-power-of-two depths.
Adds programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and one-cycle overflow/underflow error pulses.
Sits between a producer and a consumer in the same clock domain, as a drop-in wherever the plain FIFO needs back-pressure headroom.

Parameters:
DATA_WIDTH, 32, bits per word (≥1)
DATA_DEPTH, 8, number of storage entries (≥2; need not be a power of two)
ALMOST_FULL_THRESH, DATA_DEPTH-2, almost_full asserts when count ≥ this value (1..DATA_DEPTH)
ALMOST_EMPTY_THRESH, 2, almost_empty asserts when count ≤ this value (0..DATA_DEPTH-1)

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous flush; empties the FIFO, config unchanged
din  input  DATA_WIDTH  write data
write_en  input  1  push request
read_en  input  1  pop request
dout  output  DATA_WIDTH  read data
empty  output  1  count == 0
full  output  1  count == DATA_DEPTH
almost_empty  output  1  count ≤ ALMOST_EMPTY_THRESH
almost_full  output  1  count ≥ ALMOST_FULL_THRESH
count  output  $clog2(DATA_DEPTH+1)  current occupancy
overflow  output  1  one-cycle pulse: rejected write
underflow  output  1  one-cycle pulse: rejected read

Behaviour:
- Reset (reset=1 at an edge): write pointer, read pointer, count, dout, overflow and underflow all go to 0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are don't-care.
- Reset overrides clear, write_en and read_en in the same cycle.
- clear=1 (reset=0): same effect as reset on the pointers, count, dout and error pulses. Overrides write_en and read_en in that cycle.
- Status flags are combinational decodes of the registered count. They change only on the edge after an accepted operation.
- Read acceptance: rd_ok = read_en && count != 0.
- Write acceptance: wr_ok = write_en && (count != DATA_DEPTH || rd_ok).
  - When full, a simultaneous read plus write is accepted; count stays the same.
- When empty, read_en with write_en: the write is accepted, the read is rejected and underflow pulses.
- Rejected write: memory and pointers unchanged; overflow=1 for exactly the next cycle.
- Rejected read: pointers unchanged; dout holds its value; underflow=1 for exactly the next cycle.
- Count update: count_next = count + wr_ok - rd_ok. No wrap; it saturates by construction at 0..DATA_DEPTH.
- Pointers: increment by 1 per accepted op and wrap from DATA_DEPTH-1 to 0. Explicit compare is used, so non-power-of-two depths are supported.
- Standard mode (no macro): on rd_ok, dout <= mem[rd_ptr] at that edge, so data is visible 1 cycle after read_en. Otherwise dout holds.
- Ordering: strict FIFO, with no bypass. A word written at edge N is readable with read_en asserted in cycle N+1 or later.
- Elaboration checks on illegal parameters (a $fatal or equivalent): DATA_DEPTH < 2, ALMOST_FULL_THRESH > DATA_DEPTH, ALMOST_EMPTY_THRESH ≥ DATA_DEPTH.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - dout = mem[rd_ptr] continuously whenever empty=0, so the head word is visible without a read.
  - read_en acknowledges and pops it; the next word appears in the following cycle.
  - dout is 0 while empty=1.
  - All flag, count and error rules are unchanged.
- Undefined: standard registered-read mode as described in Behaviour.

Test Plan:
- Reset → empty=1, almost_empty=1, full=0, almost_full=0, count=0, dout=0, no error pulses.
- Fill (DEPTH=8, thresholds 6/2): write 1..8 on consecutive cycles.
  - Expect almost_empty deasserted after count reaches 3, almost_full asserted at count=6, full=1 at count=8.
  - A 9th write → overflow pulses for 1 cycle, count stays 8.
- Drain: read 8 times → dout sequence 1..8, each one cycle after read_en. A 9th read → underflow pulse, dout holds 8, empty=1.
- Simultaneous read+write:
  - Full FIFO, write 0xA5 with read → count stays 8, no overflow; 0xA5 emerges last.
  - Empty FIFO, both asserted → count=1, underflow pulse.
- Wrap and non-power-of-two depth (DEPTH=5): 20 interleaved write/read pairs with random data → output order exactly matches input order, count never exceeds 5.
- clear with 4 entries plus write_en=1 → count=0, empty=1, and the write is dropped. Reset asserted mid-burst behaves the same.
- With SYNC_FIFO_FWFT_EN: write 0x11, 0x22 → dout=0x11 with no read; read_en → dout=0x22 next cycle.
